// File: rtl/rv32v_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32v_types_pkg                                              |
// | Description : Shared types and encodings for the RV32V vector config CSR   |
// |               path: SEW/LMUL encodings, the packed vtype layout and the    |
// |               vset sequencing state enumeration.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rv32v_types_pkg;

  typedef logic [2:0] vsew_t;
  typedef logic [2:0] vlmul_t;

  // SEW encodings (vtype[5:3]); 1xx is reserved.
  localparam vsew_t c_sew_e8  = 3'b000;
  localparam vsew_t c_sew_e16 = 3'b001;
  localparam vsew_t c_sew_e32 = 3'b010;
  localparam vsew_t c_sew_e64 = 3'b011;

  // LMUL encodings (vtype[2:0]); 100 is reserved.
  localparam vlmul_t c_lmul_m1   = 3'b000;
  localparam vlmul_t c_lmul_m2   = 3'b001;
  localparam vlmul_t c_lmul_m4   = 3'b010;
  localparam vlmul_t c_lmul_m8   = 3'b011;
  localparam vlmul_t c_lmul_rsvd = 3'b100;
  localparam vlmul_t c_lmul_mf8  = 3'b101;
  localparam vlmul_t c_lmul_mf4  = 3'b110;
  localparam vlmul_t c_lmul_mf2  = 3'b111;

  // vtype value after reset or after an illegal vset: only vill set.
  localparam logic [31:0] c_vtype_reset = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } vcsr_state_t;

  typedef struct packed {
    logic        vill;
    logic [22:0] reserved;
    logic        vma;
    logic        vta;
    vsew_t       vsew;
    vlmul_t      vlmul;
  } vtype_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a <= b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32v_vcsr_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32v_vcsr_unit_if                                           |
// | Description : Decode-to-vcsr request/response bundle.                      |
// |   req_valid/req_ready : request handshake (decode holds until ready)       |
// |   req_avl, req_vtype  : AVL and requested vtype                            |
// |   req_rs1_zero/rd_zero: x0 flags for the rs1 and rd fields                 |
// |   done                : one-cycle commit pulse                             |
// |   rd_wen, rd_data     : rd writeback of the new vl                         |
// |   master = decode side, slave = vcsr unit side.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rv32v_vcsr_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_avl;
  logic [31:0] req_vtype;
  logic        req_rs1_zero;
  logic        req_rd_zero;
  logic        done;
  logic        rd_wen;
  logic [31:0] rd_data;

  modport master (
    output req_valid, req_avl, req_vtype, req_rs1_zero, req_rd_zero,
    input  req_ready, done, rd_wen, rd_data
  );

  modport slave (
    input  req_valid, req_avl, req_vtype, req_rs1_zero, req_rd_zero,
    output req_ready, done, rd_wen, rd_data
  );

endinterface
`default_nettype wire

// File: rtl/rv32v_vlmax_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32v_vlmax_calc                                             |
// | Description : Combinational VLMAX and SEW/LMUL legality for a vtype.       |
// |   vsew, vlmul : requested SEW and LMUL encodings                           |
// |   vlmax       : (VLEN/SEW)*LMUL, zero when the combination is illegal      |
// |   legal       : SEW/LMUL combination is supported                          |
// |   Reserved-bit checking of vtype is left to the caller.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv32v_vlmax_calc
  import rv32v_types_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  vsew_t       vsew,
  input  vlmul_t      vlmul,
  output logic [31:0] vlmax,
  output logic        legal
);

  localparam int c_vlen_log2 = $clog2(VLEN);
  localparam int c_elen_log2 = $clog2(ELEN);

  int   sew_log2;
  int   lmul_log2;
  int   shamt;
  logic sew_ok;
  logic lmul_ok;
  logic frac_ok;

  always_comb begin
    sew_log2 = 3;
    sew_ok   = 1'b1;
    case (vsew)
      c_sew_e8:  sew_log2 = 3;
      c_sew_e16: sew_log2 = 4;
      c_sew_e32: sew_log2 = 5;
      c_sew_e64: sew_log2 = 6;
      default:   sew_ok   = 1'b0;
    endcase

    lmul_log2 = 0;
    lmul_ok   = 1'b1;
    case (vlmul)
      c_lmul_m1:   lmul_log2 = 0;
      c_lmul_m2:   lmul_log2 = 1;
      c_lmul_m4:   lmul_log2 = 2;
      c_lmul_m8:   lmul_log2 = 3;
      c_lmul_mf2:  lmul_log2 = -1;
      c_lmul_mf4:  lmul_log2 = -2;
      c_lmul_mf8:  lmul_log2 = -3;
      c_lmul_rsvd: lmul_ok   = 1'b0;
      default:     lmul_ok   = 1'b0;
    endcase

    // Fractional LMUL: SEW must fit in ELEN*LMUL, i.e. log2(SEW) <= log2(ELEN) + log2(LMUL).
    frac_ok = (lmul_log2 >= 0) || (sew_log2 <= c_elen_log2 + lmul_log2);

    legal = sew_ok && lmul_ok && (sew_log2 <= c_elen_log2) && frac_ok;

    // VLMAX is always a power of two, so it is a single shift.
    shamt = c_vlen_log2 - sew_log2 + lmul_log2;
    vlmax = 32'd0;
    if (legal && (shamt >= 0) && (shamt <= 31)) begin
      vlmax = 32'd1 << shamt[4:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv32v_vcsr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32v_vcsr_unit                                              |
// | Description : Vector configuration CSRs (vtype, vl, vstart) and the        |
// |               vsetvli/vsetivli/vsetvl sequencer. A request is accepted,    |
// |               held until in-flight vector work drains, then committed in   |
// |               one cycle with the new vl returned for rd writeback.         |
// |   CLK, nRST        : clock, asynchronous active-low reset                  |
// |   bus (slave)      : decode request / rd writeback bundle                  |
// |   flush            : aborts a request still waiting in DRAIN               |
// |   vbusy            : vector work in flight; holds the request in DRAIN     |
// |   vstart_wen/wdata : CSR-instruction or trap write of vstart               |
// |   vsew..vtype      : current configuration state                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv32v_vcsr_unit
  import rv32v_types_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  rv32v_vcsr_unit_if.slave    bus,
  input  logic                flush,
  input  logic                vbusy,
  input  logic                vstart_wen,
  input  logic [31:0]         vstart_wdata,
  output vsew_t               vsew,
  output vlmul_t              vlmul,
  output logic                vta,
  output logic                vma,
  output logic                vill,
  output logic [31:0]         vl,
  output logic [31:0]         vstart,
  output logic [31:0]         vtype
);

  vcsr_state_t r_state;

  // Latched request
  vtype_t      r_req_vtype;
  logic [31:0] r_avl;
  logic        r_rs1_zero;
  logic        r_rd_zero;

  // Architectural CSRs
  vtype_t      r_csr_vtype;
  logic [31:0] r_vl;
  logic [31:0] r_vstart;

  // Registered handshake/writeback outputs
  logic        r_ready;
  logic        r_done;
  logic        r_rd_wen;
  logic [31:0] r_rd_data;

  logic [31:0] w_vlmax;
  logic        w_calc_legal;
  logic        w_legal;
  logic [31:0] w_new_vl;
  vtype_t      w_new_vtype;
  logic        w_unused;

  rv32v_vlmax_calc #(
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_vlmax_calc (
    .vsew  (r_req_vtype.vsew),
    .vlmul (r_req_vtype.vlmul),
    .vlmax (w_vlmax),
    .legal (w_calc_legal)
  );

  // The requested vill bit carries no meaning on input.
  assign w_unused = r_req_vtype.vill;

  assign w_legal = w_calc_legal && !(|r_req_vtype.reserved);

  always_comb begin
    w_new_vl = 32'd0;
    if (w_legal) begin
      if (r_rs1_zero && !r_rd_zero) begin
        w_new_vl = w_vlmax;
      end else if (r_rs1_zero) begin
        // rs1=x0, rd=x0: keep the current vl, clamped to the new VLMAX.
        w_new_vl = min_u32(r_vl, w_vlmax);
      end else begin
        w_new_vl = min_u32(r_avl, w_vlmax);
      end
    end
  end

  always_comb begin
    w_new_vtype = '0;
    if (w_legal) begin
      w_new_vtype.vma   = r_req_vtype.vma;
      w_new_vtype.vta   = r_req_vtype.vta;
      w_new_vtype.vsew  = r_req_vtype.vsew;
      w_new_vtype.vlmul = r_req_vtype.vlmul;
    end else begin
      w_new_vtype.vill  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_req_vtype <= '0;
      r_avl       <= 32'd0;
      r_rs1_zero  <= 1'b0;
      r_rd_zero   <= 1'b0;
      r_csr_vtype <= vtype_t'(c_vtype_reset);
      r_vl        <= 32'd0;
      r_vstart    <= 32'd0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_rd_wen    <= 1'b0;
      r_rd_data   <= 32'd0;
    end else begin
      r_done    <= 1'b0;
      r_rd_wen  <= 1'b0;
      r_rd_data <= 32'd0;

      // A vstart write lands in any state; the COMMIT branch below overrides it.
      if (vstart_wen) begin
        r_vstart <= vstart_wdata;
      end

      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_req_vtype <= vtype_t'(bus.req_vtype);
            r_avl       <= bus.req_avl;
            r_rs1_zero  <= bus.req_rs1_zero;
            r_rd_zero   <= bus.req_rd_zero;
            r_ready     <= 1'b0;
            r_state     <= DRAIN;
          end
        end

        DRAIN: begin
          if (flush) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else if (!vbusy) begin
            // Outputs for the COMMIT cycle are prepared here so they are registered.
            // vl cannot change during DRAIN, so the clamp result stays valid.
            r_done    <= 1'b1;
            r_rd_wen  <= !r_rd_zero;
            r_rd_data <= w_new_vl;
            r_state   <= COMMIT;
          end
        end

        COMMIT: begin
          r_csr_vtype <= w_new_vtype;
          r_vl        <= r_rd_data;
          r_vstart    <= 32'd0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.done      = r_done;
  assign bus.rd_wen    = r_rd_wen;
  assign bus.rd_data   = r_rd_data;

  assign vsew   = r_csr_vtype.vsew;
  assign vlmul  = r_csr_vtype.vlmul;
  assign vta    = r_csr_vtype.vta;
  assign vma    = r_csr_vtype.vma;
  assign vill   = r_csr_vtype.vill;
  assign vtype  = r_csr_vtype;
  assign vl     = r_vl;
  assign vstart = r_vstart;

endmodule
`default_nettype wire

// File: tb/tb_rv32v_vcsr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rv32v_vcsr_unit                                           |
// | Description : Directed self-checking bench for rv32v_vcsr_unit with        |
// |               VLEN=128, ELEN=32. Expected rd writebacks are queued when a  |
// |               request is driven and popped by a monitor on each done.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rv32v_vcsr_unit;
  import rv32v_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        flush;
  logic        vbusy;
  logic        vstart_wen;
  logic [31:0] vstart_wdata;
  vsew_t       vsew;
  vlmul_t      vlmul;
  logic        vta;
  logic        vma;
  logic        vill;
  logic [31:0] vl;
  logic [31:0] vstart;
  logic [31:0] vtype;

  rv32v_vcsr_unit_if bus();

  rv32v_vcsr_unit #(
    .VLEN (128),
    .ELEN (32)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .bus          (bus),
    .flush        (flush),
    .vbusy        (vbusy),
    .vstart_wen   (vstart_wen),
    .vstart_wdata (vstart_wdata),
    .vsew         (vsew),
    .vlmul        (vlmul),
    .vta          (vta),
    .vma          (vma),
    .vill         (vill),
    .vl           (vl),
    .vstart       (vstart),
    .vtype        (vtype)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] vl;
    logic        wen;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Writeback monitor: every done must match the oldest queued expectation,
  // and rd outputs must be quiet between commits.
  always @(negedge CLK) begin
    if (nRST) begin
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("done_without_request", {31'b0, bus.done}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rd_data", bus.rd_data, mon_e.vl);
          check("rd_wen", {31'b0, bus.rd_wen}, {31'b0, mon_e.wen});
        end
      end else begin
        check("rd_quiet", bus.rd_data | {31'b0, bus.rd_wen}, 32'd0);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    check({tag, "_done"}, {31'b0, bus.done}, 32'd0);
    check({tag, "_rd"}, bus.rd_data | {31'b0, bus.rd_wen}, 32'd0);
    check({tag, "_vl"}, vl, 32'd0);
    check({tag, "_vstart"}, vstart, 32'd0);
    check({tag, "_vtype"}, vtype, 32'h8000_0000);
    check({tag, "_fields"}, {23'b0, vill, vma, vta, vsew, vlmul}, {23'b0, 1'b1, 8'h00});
  endtask

  // Issue one vset, hold vbusy for 'busy' DRAIN cycles, check commit latency
  // and the CSR state visible the cycle after commit. 'poke' drives a vstart
  // write of 7 and a flush during the COMMIT cycle.
  task automatic vset(input string tag, input logic [31:0] avl, input logic [31:0] vt,
                      input logic rs1z, input logic rdz, input int busy,
                      input logic [31:0] exp_vl, input logic exp_vill, input logic poke);
    int          t0;
    int          w;
    logic [31:0] exp_vt;
    exp_vt = exp_vill ? 32'h8000_0000 : {24'b0, vt[7:0]};
    check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    sb_q.push_back('{exp_vl, !rdz});
    bus.req_valid    = 1'b1;
    bus.req_avl      = avl;
    bus.req_vtype    = vt;
    bus.req_rs1_zero = rs1z;
    bus.req_rd_zero  = rdz;
    t0 = cyc;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < busy; i++) begin
      vbusy = 1'b1;
      tick();
    end
    vbusy = 1'b0;
    w = 0;
    while (bus.done !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_latency"}, 32'(cyc - t0), 32'(2 + busy));
    check({tag, "_ready_commit"}, {31'b0, bus.req_ready}, 32'd0);
    if (poke) begin
      vstart_wen   = 1'b1;
      vstart_wdata = 32'd7;
      flush        = 1'b1;
    end
    tick();
    vstart_wen = 1'b0;
    flush      = 1'b0;
    check({tag, "_vl"}, vl, exp_vl);
    check({tag, "_vtype"}, vtype, exp_vt);
    check({tag, "_fields"}, {23'b0, vill, vma, vta, vsew, vlmul}, {23'b0, exp_vt[31], exp_vt[7:0]});
    check({tag, "_vstart"}, vstart, 32'd0);
    check({tag, "_done_after"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_avl      = 32'd0;
    bus.req_vtype    = 32'd0;
    bus.req_rs1_zero = 1'b0;
    bus.req_rd_zero  = 1'b0;
    flush            = 1'b0;
    vbusy            = 1'b0;
    vstart_wen       = 1'b0;
    vstart_wdata     = 32'd0;

    repeat (2) tick();
    check_reset_state("in_reset");
    nRST = 1'b1;
    repeat (2) tick();
    check_reset_state("idle");

    // vstart written in IDLE, then cleared by the next commit.
    vstart_wen   = 1'b1;
    vstart_wdata = 32'd5;
    tick();
    vstart_wen = 1'b0;
    check("vstart_idle5", vstart, 32'd5);

    // e32 m1 ta ma, avl=10: VLMAX=4.
    vset("e32m1", 32'd10, 32'h0000_00D0, 1'b0, 1'b0, 0, 32'd4, 1'b0, 1'b0);
    // e8 m8, rs1=x0 rd!=x0: VLMAX=128.
    vset("e8m8_max", 32'd0, 32'h0000_0003, 1'b1, 1'b0, 0, 32'd128, 1'b0, 1'b0);
    // e8 mf4, avl=5: VLMAX=4.
    vset("e8mf4", 32'd5, 32'h0000_0006, 1'b0, 1'b0, 0, 32'd4, 1'b0, 1'b0);
    // e8 mf8 needs SEW <= ELEN/8 = 4, so it is illegal with ELEN=32.
    vset("e8mf8", 32'd5, 32'h0000_0005, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    // e8 m1, avl=100: VLMAX=16.
    vset("e8m1", 32'd100, 32'h0000_0000, 1'b0, 1'b0, 0, 32'd16, 1'b0, 1'b0);
    // Keep-vl form: e16 m1 VLMAX=8 clamps 16 -> 8; rd=x0 so no writeback.
    vset("keep_e16", 32'd0, 32'h0000_0008, 1'b1, 1'b1, 0, 32'd8, 1'b0, 1'b0);
    // Keep-vl form: e8 m2 VLMAX=32 keeps 8.
    vset("keep_e8m2", 32'd0, 32'h0000_0001, 1'b1, 1'b1, 0, 32'd8, 1'b0, 1'b0);
    // Illegal vtypes.
    vset("e32mf2", 32'd9, 32'h0000_0017, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    vset("rsvd8", 32'd9, 32'h0000_0100, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    vset("lmul100", 32'd9, 32'h0000_0004, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    vset("e64", 32'd9, 32'h0000_0018, 1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    // Keep-vl after illegal: old vl 0 stays 0, vtype becomes legal.
    vset("keep_after_vill", 32'd0, 32'h0000_0000, 1'b1, 1'b1, 0, 32'd0, 1'b0, 1'b0);
    // vbusy held 3 DRAIN cycles: done 3 cycles later; avl below VLMAX.
    vset("busy3", 32'd3, 32'h0000_0010, 1'b0, 1'b0, 3, 32'd3, 1'b0, 1'b0);
    // vstart write and flush during COMMIT: commit still lands, vstart cleared.
    vset("commit_poke", 32'd20, 32'h0000_0010, 1'b0, 1'b0, 0, 32'd4, 1'b0, 1'b1);

    // Flush during DRAIN: no done, CSRs unchanged, ready returns.
    bus.req_valid    = 1'b1;
    bus.req_avl      = 32'd1;
    bus.req_vtype    = 32'h0000_0003;
    bus.req_rs1_zero = 1'b0;
    bus.req_rd_zero  = 1'b0;
    vbusy            = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("flush_drain_ready", {31'b0, bus.req_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vbusy = 1'b0;
    check("flush_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (3) tick();
    check("flush_vl", vl, 32'd4);
    check("flush_vtype", vtype, 32'h0000_0010);

    // vstart written in IDLE.
    vstart_wen   = 1'b1;
    vstart_wdata = 32'd7;
    tick();
    vstart_wen = 1'b0;
    check("vstart_idle7", vstart, 32'd7);

    // Reset asserted while a request waits in DRAIN.
    bus.req_valid    = 1'b1;
    bus.req_avl      = 32'd2;
    bus.req_vtype    = 32'h0000_0010;
    bus.req_rs1_zero = 1'b0;
    bus.req_rd_zero  = 1'b0;
    vbusy            = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    #2 nRST = 1'b0;
    #1;
    check_reset_state("async_reset");
    vbusy = 1'b0;
    tick();
    nRST = 1'b1;
    repeat (3) tick();
    check_reset_state("post_reset");

    // Normal operation after reset: e16 m2, avl=20: VLMAX=16.
    vset("after_reset", 32'd20, 32'h0000_0009, 1'b0, 1'b0, 0, 32'd16, 1'b0, 1'b0);

    repeat (2) tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
